// File: rtl/rmt_pipe_pkg.sv
// rtl/rmt_pipe_pkg.sv - shared RMT pipeline constants, PHV field offsets and clog2 helper
package rmt_pipe_pkg;

    localparam int PHV_LEN_DEF        = 1024;
    localparam int C_VLANID_WIDTH_DEF = 12;

    // PHV layout from LSB: metadata, 2-byte, 4-byte, 6-byte container banks
    localparam int PHV_CONT_NUM = 8;
    localparam int PHV_META_W   = 256;
    localparam int PHV_META_LSB = 0;
    localparam int PHV_2B_LSB   = PHV_META_LSB + PHV_META_W;
    localparam int PHV_4B_LSB   = PHV_2B_LSB + 16 * PHV_CONT_NUM;
    localparam int PHV_6B_LSB   = PHV_4B_LSB + 32 * PHV_CONT_NUM;
    localparam int PHV_END      = PHV_6B_LSB + 48 * PHV_CONT_NUM;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/phv_issue_if.sv
// rtl/phv_issue_if.sv - parser-side and stage-side handshake bundle of phv_issue
interface phv_issue_if
    import rmt_pipe_pkg::*;
#(
    parameter int PHV_LEN        = PHV_LEN_DEF,
    parameter int C_VLANID_WIDTH = C_VLANID_WIDTH_DEF
);
    logic [PHV_LEN-1:0]        phv_in;
    logic                      phv_in_valid;
    logic                      phv_ready_out;
    logic [C_VLANID_WIDTH-1:0] vlan_in;
    logic                      vlan_in_valid;
    logic                      vlan_ready_out;
    logic [PHV_LEN-1:0]        phv_out;
    logic                      phv_out_valid;
    logic                      stage_ready_in;
    logic [C_VLANID_WIDTH-1:0] vlan_out;
    logic                      vlan_out_valid;
    logic                      vlan_ready_in;

    // issuer side
    modport master (
        input  phv_in, phv_in_valid, vlan_in, vlan_in_valid, stage_ready_in, vlan_ready_in,
        output phv_ready_out, vlan_ready_out, phv_out, phv_out_valid, vlan_out, vlan_out_valid
    );

    // parser/stage environment side
    modport slave (
        output phv_in, phv_in_valid, vlan_in, vlan_in_valid, stage_ready_in, vlan_ready_in,
        input  phv_ready_out, vlan_ready_out, phv_out, phv_out_valid, vlan_out, vlan_out_valid
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic synchronous FIFO with registered pop data
module sync_fifo
    import rmt_pipe_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] data_q;
    logic             push_ok;
    logic             pop_ok;

    // a pop frees the slot in the same edge, so a full FIFO still accepts push+pop
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign pop_data = data_q;

    // storage array, no reset needed since occupancy guards every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // pointers, occupancy and registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                data_q   <= mem_q[rd_ptr_q];
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/phv_issue.sv
// rtl/phv_issue.sv - VLAN-before-PHV issuer for stage 0; optional stats under PHV_ISSUE_STATS_EN
module phv_issue
    import rmt_pipe_pkg::*;
#(
    parameter int PHV_LEN        = PHV_LEN_DEF,
    parameter int C_VLANID_WIDTH = C_VLANID_WIDTH_DEF,
    parameter int FIFO_DEPTH     = 8,
    parameter int LEAD_MAX       = 4
) (
    input  logic        axis_clk,
    input  logic        aresetn,
    phv_issue_if.master bus
`ifdef PHV_ISSUE_STATS_EN
    ,
    output logic [31:0] stat_phv_cnt,
    output logic [31:0] stat_drop_cnt
`endif
);
    localparam int LW = clog2(LEAD_MAX) + 1;
    localparam int CW = clog2(FIFO_DEPTH) + 1;

    logic                      phv_empty, phv_full, vlan_empty, vlan_full;
    logic [CW-1:0]             phv_cnt, vlan_cnt, phv_cnt_d, vlan_cnt_d;
    logic [PHV_LEN-1:0]        phv_data;
    logic [C_VLANID_WIDTH-1:0] vlan_data;
    logic                      phv_issue_w, vlan_issue_w;
    logic                      phv_drop, vlan_drop;
    logic [LW-1:0]             lead_q, lead_d;
    logic                      phv_vld_q, vlan_vld_q, phv_rdy_q, vlan_rdy_q;

    sync_fifo #(.WIDTH(PHV_LEN), .DEPTH(FIFO_DEPTH)) u_phv_fifo (
        .clk(axis_clk), .rst_n(aresetn),
        .push(bus.phv_in_valid), .push_data(bus.phv_in),
        .pop(phv_issue_w), .pop_data(phv_data),
        .empty(phv_empty), .full(phv_full), .count(phv_cnt)
    );

    sync_fifo #(.WIDTH(C_VLANID_WIDTH), .DEPTH(FIFO_DEPTH)) u_vlan_fifo (
        .clk(axis_clk), .rst_n(aresetn),
        .push(bus.vlan_in_valid), .push_data(bus.vlan_in),
        .pop(vlan_issue_w), .pop_data(vlan_data),
        .empty(vlan_empty), .full(vlan_full), .count(vlan_cnt)
    );

    // a VLAN may run ahead by LEAD_MAX; a PHV needs an already-issued VLAN
    assign vlan_issue_w = !vlan_empty && bus.vlan_ready_in && (lead_q < LW'(LEAD_MAX));
    assign phv_issue_w  = !phv_empty && bus.stage_ready_in && (lead_q != '0);

    assign phv_drop  = bus.phv_in_valid && phv_full && !phv_issue_w;
    assign vlan_drop = bus.vlan_in_valid && vlan_full && !vlan_issue_w;

    assign phv_cnt_d  = phv_cnt + CW'(bus.phv_in_valid && !phv_drop) - CW'(phv_issue_w);
    assign vlan_cnt_d = vlan_cnt + CW'(bus.vlan_in_valid && !vlan_drop) - CW'(vlan_issue_w);

    // lead tracks VLANs issued minus PHVs issued
    always_comb begin
        lead_d = lead_q;
        if (vlan_issue_w && !phv_issue_w) begin
            lead_d = lead_q + LW'(1);
        end else if (phv_issue_w && !vlan_issue_w) begin
            lead_d = lead_q - LW'(1);
        end
    end

    // issue pulses, upstream ready with one slot of slack, and lead counter
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            lead_q     <= '0;
            phv_vld_q  <= 1'b0;
            vlan_vld_q <= 1'b0;
            phv_rdy_q  <= 1'b0;
            vlan_rdy_q <= 1'b0;
        end else begin
            lead_q     <= lead_d;
            phv_vld_q  <= phv_issue_w;
            vlan_vld_q <= vlan_issue_w;
            phv_rdy_q  <= (phv_cnt_d <= CW'(FIFO_DEPTH - 2));
            vlan_rdy_q <= (vlan_cnt_d <= CW'(FIFO_DEPTH - 2));
        end
    end

    assign bus.phv_out        = phv_data;
    assign bus.vlan_out       = vlan_data;
    assign bus.phv_out_valid  = phv_vld_q;
    assign bus.vlan_out_valid = vlan_vld_q;
    assign bus.phv_ready_out  = phv_rdy_q;
    assign bus.vlan_ready_out = vlan_rdy_q;

`ifdef PHV_ISSUE_STATS_EN
    logic [31:0] stat_phv_q, stat_drop_q;

    // issued-PHV and dropped-write counters, wrapping at 32 bits
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            stat_phv_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_phv_q  <= stat_phv_q + 32'(phv_issue_w);
            stat_drop_q <= stat_drop_q + 32'(phv_drop) + 32'(vlan_drop);
        end
    end

    assign stat_phv_cnt  = stat_phv_q;
    assign stat_drop_cnt = stat_drop_q;
`endif
endmodule

// File: tb/tb_phv_issue.sv
// tb/tb_phv_issue.sv - scoreboard bench for phv_issue
`timescale 1ns/1ps
module tb_phv_issue;
    import rmt_pipe_pkg::*;

    localparam int PL       = 1024;
    localparam int VW       = 12;
    localparam int LEAD_MAX = 4;

    logic axis_clk = 1'b0;
    logic aresetn  = 1'b0;
    always #5 axis_clk = ~axis_clk;

    phv_issue_if #(.PHV_LEN(PL), .C_VLANID_WIDTH(VW)) bus();

`ifdef PHV_ISSUE_STATS_EN
    logic [31:0] stat_phv_cnt, stat_drop_cnt;
`endif

    phv_issue #(.PHV_LEN(PL), .C_VLANID_WIDTH(VW), .FIFO_DEPTH(8), .LEAD_MAX(LEAD_MAX)) dut (
        .axis_clk(axis_clk),
        .aresetn(aresetn),
        .bus(bus)
`ifdef PHV_ISSUE_STATS_EN
        ,
        .stat_phv_cnt(stat_phv_cnt),
        .stat_drop_cnt(stat_drop_cnt)
`endif
    );

    logic [PL-1:0] phv_q[$];
    logic [VW-1:0] vlan_q[$];
    int            vlan_cyc_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vlan_seen = 0;
    int phv_seen = 0;
    int phv_base = 0;

    function automatic logic [PL-1:0] mk_phv(input logic [31:0] w);
        return {(PL/32){w}};
    endfunction

    // advance one cycle, sample 1ns after the edge and score any issue pulses
    task automatic tick();
        logic [PL-1:0] pexp;
        logic [VW-1:0] vexp;
        int vprev;
        @(posedge axis_clk);
        #1;
        cyc++;
        vprev = vlan_seen;
        if (bus.vlan_out_valid) begin
            checks++;
            if (vlan_q.size() == 0) begin
                errors++;
                $display("FAIL vlan_unexpected got=%h required=none", bus.vlan_out);
            end else begin
                vexp = vlan_q.pop_front();
                if (bus.vlan_out !== vexp) begin
                    errors++;
                    $display("FAIL vlan_data got=%h required=%h", bus.vlan_out, vexp);
                end
            end
            vlan_seen++;
            vlan_cyc_q.push_back(cyc);
        end
        if (bus.phv_out_valid) begin
            checks++;
            if (phv_q.size() == 0) begin
                errors++;
                $display("FAIL phv_unexpected got=%h required=none", bus.phv_out[63:0]);
            end else begin
                pexp = phv_q.pop_front();
                if (bus.phv_out !== pexp) begin
                    errors++;
                    $display("FAIL phv_data got=%h required=%h", bus.phv_out[63:0], pexp[63:0]);
                end
            end
            checks++;
            if (phv_seen >= vprev) begin
                errors++;
                $display("FAIL phv_before_vlan phv_issued=%0d vlans_before=%0d", phv_seen + 1, vprev);
            end
            phv_seen++;
        end
        if (bus.vlan_out_valid || bus.phv_out_valid) begin
            checks++;
            if (vlan_seen - phv_seen > LEAD_MAX || vlan_seen < phv_seen) begin
                errors++;
                $display("FAIL lead_range got=%0d required=0..%0d", vlan_seen - phv_seen, LEAD_MAX);
            end
        end
    endtask

    task automatic wr(input logic dv, input logic [VW-1:0] v, input logic dp, input logic [PL-1:0] p);
        bus.vlan_in       = v;
        bus.vlan_in_valid = dv;
        bus.phv_in        = p;
        bus.phv_in_valid  = dp;
        if (dv) vlan_q.push_back(v);
        if (dp) phv_q.push_back(p);
        tick();
        bus.vlan_in_valid = 1'b0;
        bus.phv_in_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((vlan_q.size() != 0 || phv_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        idle(4);
        checks++;
        if (vlan_q.size() != 0 || phv_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending_vlan=%0d pending_phv=%0d required=0", name, vlan_q.size(), phv_q.size());
        end
        checks++;
        if (vlan_seen != phv_seen) begin
            errors++;
            $display("FAIL %s_lead_end got=%0d required=0", name, vlan_seen - phv_seen);
        end
    endtask

    task automatic test_reset();
        idle(2);
        checks++;
        if (bus.phv_out_valid !== 1'b0 || bus.vlan_out_valid !== 1'b0 ||
            bus.phv_ready_out !== 1'b0 || bus.vlan_ready_out !== 1'b0 ||
            bus.phv_out !== '0 || bus.vlan_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b%b%b%b required=0000", bus.phv_out_valid,
                     bus.vlan_out_valid, bus.phv_ready_out, bus.vlan_ready_out);
        end
        aresetn = 1'b1;
        tick();
        checks++;
        if (bus.phv_ready_out !== 1'b1 || bus.vlan_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b%b required=11", bus.phv_ready_out, bus.vlan_ready_out);
        end
    endtask

    task automatic test_order();
        bus.stage_ready_in = 1'b1;
        bus.vlan_ready_in  = 1'b1;
        vlan_cyc_q.delete();
        for (int i = 1; i <= 3; i++) wr(1'b1, VW'(i), 1'b0, '0);
        wr(1'b0, '0, 1'b1, mk_phv(32'hAAAA_0001));
        wr(1'b0, '0, 1'b1, mk_phv(32'hBBBB_0002));
        wr(1'b0, '0, 1'b1, mk_phv(32'hCCCC_0003));
        drain("order");
        checks++;
        if (vlan_cyc_q.size() != 3) begin
            errors++;
            $display("FAIL order_vlan_count got=%0d required=3", vlan_cyc_q.size());
        end else if (vlan_cyc_q[1] != vlan_cyc_q[0] + 1 || vlan_cyc_q[2] != vlan_cyc_q[1] + 1) begin
            errors++;
            $display("FAIL order_vlan_consecutive got=%0d,%0d,%0d required=consecutive",
                     vlan_cyc_q[0], vlan_cyc_q[1], vlan_cyc_q[2]);
        end
    endtask

    task automatic test_no_vlan();
        int p0;
        p0 = phv_seen;
        wr(1'b0, '0, 1'b1, mk_phv(32'hDDDD_0004));
        wr(1'b0, '0, 1'b1, mk_phv(32'hEEEE_0005));
        idle(20);
        checks++;
        if (phv_seen != p0) begin
            errors++;
            $display("FAIL novlan_hold got=%0d required=%0d", phv_seen - p0, 0);
        end
        wr(1'b1, 12'h005, 1'b0, '0);
        idle(10);
        checks++;
        if (phv_seen != p0 + 1) begin
            errors++;
            $display("FAIL novlan_release got=%0d required=1", phv_seen - p0);
        end
        wr(1'b1, 12'h006, 1'b0, '0);
        drain("novlan");
    endtask

    task automatic test_lead();
        int v0, p0;
        v0 = vlan_seen;
        p0 = phv_seen;
        bus.stage_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) wr(1'b1, VW'(12'h010 + i), 1'b0, '0);
        idle(15);
        checks++;
        if (vlan_seen - v0 != LEAD_MAX) begin
            errors++;
            $display("FAIL lead_stall got=%0d required=%0d", vlan_seen - v0, LEAD_MAX);
        end
        bus.stage_ready_in = 1'b1;
        wr(1'b0, '0, 1'b1, mk_phv(32'h1111_0000));
        idle(10);
        checks++;
        if (vlan_seen - v0 != LEAD_MAX + 1 || phv_seen - p0 != 1) begin
            errors++;
            $display("FAIL lead_step got=%0d/%0d required=%0d/1", vlan_seen - v0, phv_seen - p0, LEAD_MAX + 1);
        end
        for (int i = 1; i < 8; i++) wr(1'b0, '0, 1'b1, mk_phv(32'h1111_0000 + i));
        drain("lead");
    endtask

    task automatic test_fill();
        bus.stage_ready_in = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr(1'b0, '0, (i < 8), mk_phv(32'h5000_0000 + i));
            if (i == 8) begin
                bus.phv_in       = mk_phv(32'h5000_0008);
                bus.phv_in_valid = 1'b1;
                tick();
                bus.phv_in_valid = 1'b0;
            end
            checks++;
            if (bus.phv_ready_out !== (i < 6)) begin
                errors++;
                $display("FAIL fill_ready write=%0d got=%b required=%b", i + 1, bus.phv_ready_out, (i < 6));
            end
        end
`ifdef PHV_ISSUE_STATS_EN
        checks++;
        if (stat_drop_cnt !== 32'd1) begin
            errors++;
            $display("FAIL fill_drop_cnt got=%0d required=1", stat_drop_cnt);
        end
`endif
        bus.stage_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) wr(1'b1, VW'(12'h040 + i), 1'b0, '0);
        drain("fill");
    endtask

    task automatic test_stall();
        int p_at;
        p_at = phv_seen;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                bus.stage_ready_in = 1'b0;
                p_at = phv_seen;
            end
            wr(1'b1, VW'(12'h020 + i), 1'b1, mk_phv(32'h6000_0000 + i));
        end
        idle(6);
        checks++;
        if (phv_seen - p_at > 1) begin
            errors++;
            $display("FAIL stall_extra_pulses got=%0d required=<=1", phv_seen - p_at);
        end
        bus.stage_ready_in = 1'b1;
        drain("stall");
`ifdef PHV_ISSUE_STATS_EN
        checks++;
        if (stat_phv_cnt !== 32'(phv_seen - phv_base) || stat_drop_cnt !== 32'd1) begin
            errors++;
            $display("FAIL stats_total got=%0d/%0d required=%0d/1", stat_phv_cnt, stat_drop_cnt, phv_seen - phv_base);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int v0, p0;
        bus.stage_ready_in = 1'b0;
        bus.vlan_ready_in  = 1'b0;
        for (int i = 0; i < 3; i++) wr(1'b1, VW'(12'h070 + i), 1'b1, mk_phv(32'h7000_0000 + i));
        #3;
        aresetn = 1'b0;
        #1;
        checks++;
        if (bus.phv_out_valid !== 1'b0 || bus.vlan_out_valid !== 1'b0 ||
            bus.phv_ready_out !== 1'b0 || bus.vlan_ready_out !== 1'b0 ||
            bus.phv_out !== '0 || bus.vlan_out !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got=%b%b%b%b vlan=%h required=0", bus.phv_out_valid,
                     bus.vlan_out_valid, bus.phv_ready_out, bus.vlan_ready_out, bus.vlan_out);
        end
`ifdef PHV_ISSUE_STATS_EN
        checks++;
        if (stat_phv_cnt !== 32'd0 || stat_drop_cnt !== 32'd0) begin
            errors++;
            $display("FAIL midreset_stats got=%0d/%0d required=0/0", stat_phv_cnt, stat_drop_cnt);
        end
`endif
        vlan_q.delete();
        phv_q.delete();
        idle(2);
        aresetn = 1'b1;
        phv_base = phv_seen;
        bus.stage_ready_in = 1'b1;
        bus.vlan_ready_in  = 1'b1;
        v0 = vlan_seen;
        p0 = phv_seen;
        idle(10);
        checks++;
        if (vlan_seen != v0 || phv_seen != p0) begin
            errors++;
            $display("FAIL midreset_empty got=%0d/%0d required=0/0", vlan_seen - v0, phv_seen - p0);
        end
        wr(1'b1, 12'h007, 1'b1, mk_phv(32'h7777_0007));
        drain("midreset");
`ifdef PHV_ISSUE_STATS_EN
        checks++;
        if (stat_phv_cnt !== 32'd1) begin
            errors++;
            $display("FAIL midreset_phv_cnt got=%0d required=1", stat_phv_cnt);
        end
`endif
    endtask

    initial begin
        bus.phv_in         = '0;
        bus.phv_in_valid   = 1'b0;
        bus.vlan_in        = '0;
        bus.vlan_in_valid  = 1'b0;
        bus.stage_ready_in = 1'b0;
        bus.vlan_ready_in  = 1'b0;
        test_reset();
        test_order();
        test_no_vlan();
        test_lead();
        test_fill();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
